keypad_scanner: RTL
===================

Name: keypad_scanner

Overview:
- Input-side counterpart of the seven-segment display driver.
- Scans a 4x4 matrix keypad, debounces presses and releases, and decodes each press to a 4-bit key code.
- Accumulates hex digit entries into a 32-bit value that can feed the display's 32-bit data input.
- Sits between board keypad pins and CPU MMIO/IO logic; clk is the 100 MHz system clock.

Parameters:
- SCAN_DIV, 100000, clk cycles per scan tick (1 kHz at 100 MHz); legal range is 2 or more.
- DEBOUNCE_SCANS, 4, consecutive stable ticks required to accept a press or a release; legal range is 1 to 15.

Ports:
- clk  in  1  system clock, rising edge
- rst  in  1  synchronous reset, active-low
- row_in  in  4  keypad rows, active-low, externally pulled up, asynchronous to clk
- col_out  out  4  column drive, exactly one bit low at a time, one-hot-low
- key_valid  out  1  one-clk pulse per accepted key press
- key_code  out  4  code of the last accepted key; holds until the next press
- key_held  out  1  high while the accepted key has not yet been debounced as released
- entry_data  out  32  accumulated hex entry
- entry_done  out  1  one-clk pulse when '#' is accepted

Behaviour:
- Reset (rst==0 at a clk edge): col_out=4'b1110; key_valid=0, key_code=0, key_held=0, entry_data=0, entry_done=0; tick counter=0, debounce counters=0; state=SCAN; synchronizer flops set to 4'hF.
- Reset mid-operation (any state): same values; scanning restarts at column 0.
- row_in passes through a 2-flop synchronizer; rows_s is the synchronized value.
- Tick: the counter counts 0..SCAN_DIV-1; tick=1 for one clk when the count equals SCAN_DIV-1, then the count wraps to 0. All FSM decisions happen only on tick cycles.
- Key map, row r / column c -> code:
  - r0: 1, 2, 3, A
  - r1: 4, 5, 6, B
  - r2: 7, 8, 9, C
  - r3: '*'->E, 0, '#'->F, D
- Row selection: if several rows are low, the lowest-index low row wins.
- SCAN state, on tick:
  - rows_s==4'hF: rotate the active column c -> (c+1) mod 4 (1110 -> 1101 -> 1011 -> 0111 -> 1110).
  - Otherwise: latch col and row, set cnt=1, go DEBOUNCE; col_out is frozen.
  - If DEBOUNCE_SCANS==1, accept on this same tick.
- DEBOUNCE state, on tick:
  - Same row still lowest-low: cnt++. When cnt reaches DEBOUNCE_SCANS, accept the key and go HELD.
  - Otherwise: go SCAN and rotate the column (reject; no output change).
- Accept cycle (single clk):
  - key_valid=1; key_code=code.
  - Codes 0..D: entry_data <= {entry_data[27:0], code}; the top nibble is discarded on overflow.
  - E ('*'): entry_data <= 0.
  - F ('#'): entry_done=1; entry_data unchanged.
  - From the next clk: key_valid=0, entry_done=0, key_held=1.
- HELD state, on tick:
  - rows_s==4'hF: rel++. Otherwise: rel=0.
  - When rel reaches DEBOUNCE_SCANS: key_held=0, go SCAN, rotate the column.
  - No further key_valid is produced while HELD, so auto-repeat is not supported.
- Latency: at least 2 clk of synchronizer, plus DEBOUNCE_SCANS ticks from the first low row sample to key_valid.
- Second key pressed during HELD: ignored; held keys only count as released when all rows are high.

Test Plan:
- Bench setup for all cases: SCAN_DIV=4, DEBOUNCE_SCANS=2. The keypad model drives row_in[r]=0 iff key (r,c) is pressed and col_out[c]==0.
- Reset: hold rst=0 for 3 clk -> col_out=1110, all outputs 0; release -> col_out steps 1101, 1011, 0111, 1110 every 4 clk.
- Press '5' (r1,c1), hold 20 ticks, release -> exactly one key_valid pulse; key_code=5; entry_data=0x00000005; key_held=1 until 2 ticks after release.
- Bounce: key '7' low for 1 tick, then released -> no key_valid, entry_data unchanged, scanning resumes.
- Enter 1,2,3,A,B,C,D,0,9 -> nine key_valid pulses; entry_data=0x23ABCD09 (the '1' is shifted out).
- Press '#' -> key_code=F, entry_done and key_valid high in the same single clk, entry_data unchanged. Press '*' -> key_code=E, entry_data=0.
- Press '4' and '7' together (both c0) -> key_code=4. Assert rst=0 during HELD -> all outputs 0, col_out=1110, scanning restarts.

Source files
------------

// File: rtl/keypad_scanner.sv
// 4x4 matrix keypad scanner: column strobe, row synchronizer, press/release debounce,
// key decode and a 32-bit hex entry accumulator for the seven-segment display path.
module keypad_scanner #(
    parameter int SCAN_DIV       = 100000,
    parameter int DEBOUNCE_SCANS = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [3:0]  row_in,
    output logic [3:0]  col_out,
    output logic        key_valid,
    output logic [3:0]  key_code,
    output logic        key_held,
    output logic [31:0] entry_data,
    output logic        entry_done
);

    localparam int              TW         = $clog2(SCAN_DIV);
    localparam logic [TW-1:0]   TICK_LAST  = TW'(SCAN_DIV - 1);
    localparam logic [3:0]      DEB_TARGET = 4'(DEBOUNCE_SCANS);

    typedef enum logic [1:0] {SCAN, DEBOUNCE, HELD} state_t;

    state_t          state;
    logic [3:0]      sync1;
    logic [3:0]      rows_s;
    logic [TW-1:0]   tick_cnt;
    logic            tick;
    logic [1:0]      key_row;
    logic [3:0]      deb_cnt;
    logic [3:0]      rel_cnt;
    logic [1:0]      low_row;
    logic            low_row_valid;
    logic [1:0]      col_idx;
    logic [3:0]      new_code;
    logic            accept;

    function automatic logic [3:0] key_map(input logic [1:0] r, input logic [1:0] c);
        case ({r, c})
            4'h0: key_map = 4'h1;
            4'h1: key_map = 4'h2;
            4'h2: key_map = 4'h3;
            4'h3: key_map = 4'hA;
            4'h4: key_map = 4'h4;
            4'h5: key_map = 4'h5;
            4'h6: key_map = 4'h6;
            4'h7: key_map = 4'hB;
            4'h8: key_map = 4'h7;
            4'h9: key_map = 4'h8;
            4'hA: key_map = 4'h9;
            4'hB: key_map = 4'hC;
            4'hC: key_map = 4'hE;
            4'hD: key_map = 4'h0;
            4'hE: key_map = 4'hF;
            default: key_map = 4'hD;
        endcase
    endfunction

    // Rows are released-high, so the synchronizer idles at all-ones.
    always_ff @(posedge clk) begin
        if (!rst) begin
            sync1  <= 4'hF;
            rows_s <= 4'hF;
        end else begin
            sync1  <= row_in;
            rows_s <= sync1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst || tick) tick_cnt <= '0;
        else              tick_cnt <= tick_cnt + 1'b1;
    end

    assign tick = (tick_cnt == TICK_LAST);

    always_comb begin
        low_row = 2'd3;
        if      (!rows_s[0]) low_row = 2'd0;
        else if (!rows_s[1]) low_row = 2'd1;
        else if (!rows_s[2]) low_row = 2'd2;
        low_row_valid = (rows_s != 4'hF);
    end

    always_comb begin
        case (col_out)
            4'b1101: col_idx = 2'd1;
            4'b1011: col_idx = 2'd2;
            4'b0111: col_idx = 2'd3;
            default: col_idx = 2'd0;
        endcase
    end

    // The column is frozen outside SCAN, so the live row/column always names the candidate key.
    assign new_code = key_map(low_row, col_idx);
    assign accept   = tick && low_row_valid &&
                      (((state == SCAN) && (DEB_TARGET == 4'd1)) ||
                       ((state == DEBOUNCE) && (low_row == key_row) &&
                        (deb_cnt + 4'd1 == DEB_TARGET)));

    always_ff @(posedge clk) begin
        if (!rst) begin
            state      <= SCAN;
            col_out    <= 4'b1110;
            key_row    <= 2'd0;
            deb_cnt    <= 4'd0;
            rel_cnt    <= 4'd0;
            key_valid  <= 1'b0;
            key_code   <= 4'h0;
            key_held   <= 1'b0;
            entry_data <= 32'h0;
            entry_done <= 1'b0;
        end else begin
            key_valid  <= 1'b0;
            entry_done <= 1'b0;
            if (key_valid) key_held <= 1'b1;

            if (accept) begin
                key_valid <= 1'b1;
                key_code  <= new_code;
                state     <= HELD;
                deb_cnt   <= 4'd0;
                rel_cnt   <= 4'd0;
                case (new_code)
                    4'hF:    entry_done <= 1'b1;
                    4'hE:    entry_data <= 32'h0;
                    default: entry_data <= {entry_data[27:0], new_code};
                endcase
            end else if (tick) begin
                case (state)
                    SCAN: begin
                        if (low_row_valid) begin
                            key_row <= low_row;
                            deb_cnt <= 4'd1;
                            state   <= DEBOUNCE;
                        end else begin
                            col_out <= {col_out[2:0], col_out[3]};
                        end
                    end
                    DEBOUNCE: begin
                        if (low_row_valid && (low_row == key_row)) begin
                            deb_cnt <= deb_cnt + 4'd1;
                        end else begin
                            deb_cnt <= 4'd0;
                            state   <= SCAN;
                            col_out <= {col_out[2:0], col_out[3]};
                        end
                    end
                    HELD: begin
                        if (low_row_valid) begin
                            rel_cnt <= 4'd0;
                        end else if (rel_cnt + 4'd1 == DEB_TARGET) begin
                            rel_cnt  <= 4'd0;
                            key_held <= 1'b0;
                            state    <= SCAN;
                            col_out  <= {col_out[2:0], col_out[3]};
                        end else begin
                            rel_cnt <= rel_cnt + 4'd1;
                        end
                    end
                    default: state <= SCAN;
                endcase
            end
        end
    end

endmodule
